// File: rtl/cfu_simd_mac_pkg.sv
// cfu_simd_mac_pkg: shared opcodes, FSM states and default widths for the SIMD MAC CFU
package cfu_simd_mac_pkg;
    localparam int XLEN           = 32;
    localparam int CFU_CTRL_WIDTH = 10;
    localparam int DEF_LANE_W     = 8;
    localparam int DEF_ACC_W      = 32;
    localparam logic [2:0] CFU_OP_ADD    = 3'd1;
    localparam logic [2:0] CFU_OP_SUB    = 3'd2;
    localparam logic [2:0] CFU_OP_PADD   = 3'd3;
    localparam logic [2:0] CFU_OP_PSUB   = 3'd4;
    localparam logic [2:0] CFU_OP_DOTACC = 3'd5;
    localparam logic [2:0] CFU_OP_RDACC  = 3'd6;
    localparam logic [2:0] CFU_OP_CLRACC = 3'd7;
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
endpackage

// File: rtl/cfu_simd_mac_lane_alu.sv
// cfu_lane_alu: one packed lane add/sub; clamps per lane when CFU_SATURATE_EN is defined
module cfu_lane_alu #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         uns,
    output logic [W-1:0] y
);
    logic [W:0] s;
    assign s = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
`ifdef CFU_SATURATE_EN
    logic ovf;
    // signed overflow: operand signs agree (add) or differ (sub) and the result sign flips
    assign ovf = (sub ? a[W-1] ^ b[W-1] : ~(a[W-1] ^ b[W-1])) & (s[W-1] ^ a[W-1]);
    // unsigned carry/borrow lives in s[W]; signed clamp direction follows a's sign
    always_comb
        y = uns ? (s[W] ? (sub ? '0 : '1) : s[W-1:0])
                : (ovf ? {a[W-1], {(W-1){~a[W-1]}}} : s[W-1:0]);
`else
    logic unused;
    assign unused = uns ^ s[W];
    // plain wrapping lane arithmetic
    always_comb
        y = s[W-1:0];
`endif
endmodule

// File: rtl/cfu_simd_mac.sv
// cfu_simd_mac: scalar/SIMD add-sub plus multi-cycle dot-product accumulate; CFU_SATURATE_EN enables saturation
module cfu_simd_mac
    import cfu_simd_mac_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic                      valid_i,
    input  logic [CFU_CTRL_WIDTH-1:0] cfu_ctrl_i,
    input  logic [XLEN-1:0]           src1_i,
    input  logic [XLEN-1:0]           src2_i,
    output logic                      busy_o,
    output logic [XLEN-1:0]           rslt_o
);
    localparam int LANES = XLEN / LANE_W;
    localparam int IW    = LANES > 1 ? $clog2(LANES) : 1;
    state_t                   state, state_n;
    logic [ACC_W-1:0]         acc, acc_n;
    logic [XLEN-1:0]          a_q, b_q, simd;
    logic                     sgn_q;
    logic [IW-1:0]            idx;
    logic [2:0]               funct3;
    logic                     f7_0, accept;
    logic [LANE_W-1:0]        la, lb;
    logic signed [LANE_W:0]   ea, eb;
    logic signed [2*LANE_W+1:0] prod;
    logic signed [ACC_W:0]    sum;
    logic                     unused;
    assign funct3 = cfu_ctrl_i[2:0];
    assign f7_0   = cfu_ctrl_i[3];
    assign unused = ^cfu_ctrl_i[CFU_CTRL_WIDTH-1:4];
    assign accept = valid_i && !stall_i && state == IDLE;
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        cfu_lane_alu #(.W(LANE_W)) u_lane (
            .a   (src1_i[g*LANE_W +: LANE_W]),
            .b   (src2_i[g*LANE_W +: LANE_W]),
            .sub (funct3 == CFU_OP_PSUB),
            .uns (f7_0),
            .y   (simd[g*LANE_W +: LANE_W])
        );
    end
    assign la   = a_q[idx*LANE_W +: LANE_W];
    assign lb   = b_q[idx*LANE_W +: LANE_W];
    assign ea   = {sgn_q & la[LANE_W-1], la};
    assign eb   = {sgn_q & lb[LANE_W-1], lb};
    assign prod = ea * eb;
    assign sum  = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'(prod);
`ifdef CFU_SATURATE_EN
    // clamp to signed accumulator limits when the extra sum bit disagrees with the sign
    always_comb
        acc_n = (sum[ACC_W] != sum[ACC_W-1]) ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
`else
    logic unused_msb;
    assign unused_msb = sum[ACC_W];
    // wrapping accumulation
    always_comb
        acc_n = sum[ACC_W-1:0];
`endif
    // next-state: one lane per MAC cycle, DONE holds while stalled
    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = (accept && funct3 == CFU_OP_DOTACC) ? MAC : IDLE;
        else if (state == MAC)
            state_n = (idx == IW'(LANES - 1)) ? DONE : MAC;
        else
            state_n = stall_i ? DONE : IDLE;
    end
    // state, operand latches and accumulator
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            acc   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            idx   <= '0;
        end else begin
            state <= state_n;
            if (accept && funct3 == CFU_OP_DOTACC) begin
                a_q   <= src1_i;
                b_q   <= src2_i;
                sgn_q <= ~f7_0;
                idx   <= '0;
            end
            if (accept && funct3 == CFU_OP_CLRACC)
                acc <= f7_0 ? ACC_W'($signed(src1_i)) : '0;
            if (state == MAC) begin
                acc <= acc_n;
                idx <= idx + 1'b1;
            end
        end
    end
    // result mux: DONE shows acc, IDLE shows the combinational op, otherwise zero
    always_comb begin
        busy_o = state == MAC;
        rslt_o = state == DONE ? XLEN'(acc)
               : !(state == IDLE && valid_i) ? '0
               : funct3 == CFU_OP_ADD  ? src1_i + src2_i
               : funct3 == CFU_OP_SUB  ? src1_i - src2_i
               : (funct3 == CFU_OP_PADD || funct3 == CFU_OP_PSUB) ? simd
               : (funct3 == CFU_OP_RDACC || funct3 == CFU_OP_CLRACC) ? XLEN'(acc)
               : '0;
    end
endmodule
